// File: rtl/reciever_payload.sv
// MIL-STD-1553 payload receiver: follows the prefix stage, collects the
// remaining Manchester half-bit samples (15 data bits + parity), assembles
// the word, checks encoding and parity, and strobes the result out.
module reciever_payload #(
    parameter int DATA_BITS      = 16,
    parameter int PARITY_ODD     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx_in,
    input  logic                 i_rx_valid,
    input  logic                 i_prefix_done,
    input  logic                 i_prefix_fail,
    input  logic                 i_word_type,
    input  logic                 i_msb,
    output logic                 o_clear,
    output logic                 o_busy,
    output logic                 o_word_valid,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_word_type,
    output logic                 o_parity_err,
    output logic                 o_manchester_err,
    output logic                 o_sync_err,
    output logic                 o_timeout_err
);

    // Half-bits still to collect after the prefix: (DATA_BITS-1) data pairs
    // plus one parity pair.
    localparam int HALVES = 2 * DATA_BITS;
    localparam int CNT_W  = $clog2(HALVES + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALVES - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     half_cnt_q, half_cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 h0_q, h0_d;
    logic                 parity_q, parity_d;
    logic                 man_q, man_d;
    logic                 type_q, type_d;

    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 word_type_q, word_type_d;
    logic                 parity_err_q, parity_err_d;
    logic                 man_err_q, man_err_d;
    logic                 valid_q, valid_d;
    logic                 sync_err_q, sync_err_d;
    logic                 timeout_q, timeout_d;

    logic [GAP_W-1:0]     gap_inc;
    logic                 parity_xor;

    assign gap_inc    = gap_q + GAP_W'(1);
    assign parity_xor = ^{shift_q, parity_q};

    // The prefix stage is cleared on the same edge that captures its result.
    assign o_clear = (state_q == IDLE) && i_prefix_done;
    assign o_busy  = (state_q == COLLECT);

    assign o_word_valid     = valid_q;
    assign o_word           = word_q;
    assign o_word_type      = word_type_q;
    assign o_parity_err     = parity_err_q;
    assign o_manchester_err = man_err_q;
    assign o_sync_err       = sync_err_q;
    assign o_timeout_err    = timeout_q;

    // Next-state, decode and output-update logic.
    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        gap_d        = gap_q;
        shift_d      = shift_q;
        h0_d         = h0_q;
        parity_d     = parity_q;
        man_d        = man_q;
        type_d       = type_q;
        word_d       = word_q;
        word_type_d  = word_type_q;
        parity_err_d = parity_err_q;
        man_err_d    = man_err_q;
        valid_d      = 1'b0;
        sync_err_d   = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_prefix_done) begin
                    if (i_prefix_fail) begin
                        sync_err_d = 1'b1;
                    end else begin
                        type_d     = i_word_type;
                        shift_d    = {{(DATA_BITS-1){1'b0}}, i_msb};
                        half_cnt_d = '0;
                        gap_d      = '0;
                        man_d      = 1'b0;
                        state_d    = COLLECT;
                        // A sample coinciding with capture is payload half-bit 1.
                        if (i_rx_valid) begin
                            h0_d       = i_rx_in;
                            half_cnt_d = CNT_W'(1);
                        end
                    end
                end
            end

            COLLECT: begin
                if (i_rx_valid) begin
                    gap_d      = '0;
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                    if (!half_cnt_q[0]) begin
                        h0_d = i_rx_in;
                    end else begin
                        // Pair decodes to its first half; 00/11 is flagged but still taken.
                        if (h0_q == i_rx_in) begin
                            man_d = 1'b1;
                        end
                        if (half_cnt_q == LAST_HALF) begin
                            parity_d = h0_q;
                            state_d  = FINISH;
                        end else begin
                            shift_d = {shift_q[DATA_BITS-2:0], h0_q};
                        end
                    end
                end else if (gap_inc == GAP_LIMIT) begin
                    // Sample stream stalled: drop the partial word.
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    state_d   = IDLE;
                end else begin
                    gap_d = gap_inc;
                end
            end

            FINISH: begin
                word_d       = shift_q;
                word_type_d  = type_q;
                man_err_d    = man_q;
                parity_err_d = (PARITY_ODD != 0) ? ~parity_xor : parity_xor;
                valid_d      = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            half_cnt_q   <= '0;
            gap_q        <= '0;
            shift_q      <= '0;
            h0_q         <= 1'b0;
            parity_q     <= 1'b0;
            man_q        <= 1'b0;
            type_q       <= 1'b0;
            word_q       <= '0;
            word_type_q  <= 1'b0;
            parity_err_q <= 1'b0;
            man_err_q    <= 1'b0;
            valid_q      <= 1'b0;
            sync_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            gap_q        <= gap_d;
            shift_q      <= shift_d;
            h0_q         <= h0_d;
            parity_q     <= parity_d;
            man_q        <= man_d;
            type_q       <= type_d;
            word_q       <= word_d;
            word_type_q  <= word_type_d;
            parity_err_q <= parity_err_d;
            man_err_q    <= man_err_d;
            valid_q      <= valid_d;
            sync_err_q   <= sync_err_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule
